// File: rtl/vme_pkg.sv
// Shared definitions for the VME bus requester: signal polarity,
// number of request/grant levels and the requester state encoding.
package vme_pkg;

  // VME control lines are active-low
  localparam logic ACTIVE   = 1'b0;
  localparam logic INACTIVE = 1'b1;

  // BR0*-BR3* / BG0*-BG3*
  localparam int unsigned NUM_LEVELS = 4;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_PASS     = 3'd1,
    ST_REQUEST  = 3'd2,
    ST_GRANTED  = 3'd3,
    ST_OWNER    = 3'd4,
    ST_RELEASE  = 3'd5
  } state_t;

  // True when an active-low line is asserted
  function automatic logic is_active(input logic v);
    return (v == ACTIVE);
  endfunction

endpackage

// File: rtl/vme_sync.sv
// Two-flop synchronizer for asynchronous active-low VME inputs.
// Reset parks both stages at the inactive level so nothing downstream
// sees a spurious grant or bus clear while coming out of reset.
module vme_sync
  import vme_pkg::*;
#(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  // Metastability stage followed by the stable output stage
  always_ff @(posedge clock) begin
    if (reset) begin
      r_meta <= {WIDTH{INACTIVE}};
      r_sync <= {WIDTH{INACTIVE}};
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/vme_bus_requester.sv
// VME bus requester: requests the bus on one BR level, passes the
// daisy-chained grant when not interested, and holds BBSY* while the
// local CPU owns the bus. All outputs come straight from flops.
module vme_bus_requester
  import vme_pkg::*;
#(
  parameter int unsigned BUS_LEVEL = 3,
  parameter int unsigned BBSY_MIN  = 3,
  parameter int unsigned TIMEOUT   = 255
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  request_vme,
  input  logic                  cpu_as,
  input  logic [NUM_LEVELS-1:0] vme_bg_in,
  input  logic                  vme_bclr,
  output logic                  bus_acquired,
  output logic                  timeout_err,
  output logic [NUM_LEVELS-1:0] vme_br,
  output logic [NUM_LEVELS-1:0] vme_bg_out,
  output logic                  vme_bbsy_out
);

  localparam logic [1:0]  LVL    = 2'(BUS_LEVEL);
  localparam int unsigned WAIT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam int unsigned HOLD_W = (BBSY_MIN < 1) ? 1 : $clog2(BBSY_MIN + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((TIMEOUT < 1) ? 0 : TIMEOUT - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(BBSY_MIN);

  logic [NUM_LEVELS-1:0] w_bg_sync;
  logic                  w_bclr_sync;
  logic                  w_grant;
  logic                  w_release;

  state_t                r_state;
  logic [WAIT_W-1:0]     r_wait_cnt;
  logic [HOLD_W-1:0]     r_hold_cnt;
  logic                  r_bus_acquired;
  logic                  r_timeout_err;
  logic [NUM_LEVELS-1:0] r_br;
  logic [NUM_LEVELS-1:0] r_bg_out;
  logic                  r_bbsy;

  vme_sync #(.WIDTH(NUM_LEVELS)) u_bg_sync (
    .clock (clock),
    .reset (reset),
    .i_d   (vme_bg_in),
    .o_q   (w_bg_sync)
  );

  vme_sync #(.WIDTH(1)) u_bclr_sync (
    .clock (clock),
    .reset (reset),
    .i_d   (vme_bclr),
    .o_q   (w_bclr_sync)
  );

  // Grant for our own level, seen only through the synchronizer
  assign w_grant = is_active(w_bg_sync[LVL]);

  // Give the bus up only between CPU cycles, after the minimum BBSY hold,
  // and only if the CPU is done or the arbiter asked us to clear
  assign w_release = (r_hold_cnt >= HOLD_MAX) &&
                     !is_active(cpu_as) &&
                     (!is_active(request_vme) || is_active(w_bclr_sync));

  // Requester FSM; outputs are registered together with the next state
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state        <= ST_IDLE;
      r_wait_cnt     <= '0;
      r_hold_cnt     <= '0;
      r_bus_acquired <= INACTIVE;
      r_timeout_err  <= INACTIVE;
      r_br           <= {NUM_LEVELS{INACTIVE}};
      r_bg_out       <= {NUM_LEVELS{INACTIVE}};
      r_bbsy         <= INACTIVE;
    end else begin
      // Other levels' grants ripple through; our own level only in PASS
      r_bg_out       <= w_bg_sync;
      r_bg_out[LVL]  <= INACTIVE;
      r_bus_acquired <= INACTIVE;
      r_timeout_err  <= INACTIVE;
      r_br           <= {NUM_LEVELS{INACTIVE}};
      r_bbsy         <= INACTIVE;

      case (r_state)
        ST_IDLE: begin
          if (w_grant) begin
            r_state       <= ST_PASS;
            r_bg_out[LVL] <= ACTIVE;
          end else if (is_active(request_vme)) begin
            r_state    <= ST_REQUEST;
            r_wait_cnt <= '0;
            r_br[LVL]  <= ACTIVE;
          end
        end

        ST_PASS: begin
          if (w_grant) begin
            r_bg_out[LVL] <= ACTIVE;
          end else begin
            r_state <= ST_IDLE;
          end
        end

        ST_REQUEST: begin
          if (w_grant) begin
            r_state    <= ST_GRANTED;
            r_hold_cnt <= '0;
            r_bbsy     <= ACTIVE;
          end else if (!is_active(request_vme)) begin
            r_state <= ST_IDLE;
          end else if (r_wait_cnt == WAIT_LAST) begin
            r_state       <= ST_IDLE;
            r_timeout_err <= ACTIVE;
          end else begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
            r_br[LVL]  <= ACTIVE;
          end
        end

        ST_GRANTED: begin
          r_state        <= ST_OWNER;
          r_hold_cnt     <= '0;
          r_bus_acquired <= ACTIVE;
          r_bbsy         <= ACTIVE;
        end

        ST_OWNER: begin
          if (w_release) begin
            r_state <= ST_RELEASE;
            r_bbsy  <= ACTIVE;
          end else begin
            r_bus_acquired <= ACTIVE;
            r_bbsy         <= ACTIVE;
            if (r_hold_cnt < HOLD_MAX) begin
              r_hold_cnt <= r_hold_cnt + 1'b1;
            end
          end
        end

        ST_RELEASE: begin
          r_state <= ST_IDLE;
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus_acquired = r_bus_acquired;
  assign timeout_err  = r_timeout_err;
  assign vme_br       = r_br;
  assign vme_bg_out   = r_bg_out;
  assign vme_bbsy_out = r_bbsy;

endmodule

// File: tb/tb_vme_bus_requester.sv
// Directed bench for vme_bus_requester (BUS_LEVEL=3, BBSY_MIN=3, TIMEOUT=8).
// Inputs change and outputs are sampled 1 ns after each rising edge.
module tb_vme_bus_requester;
  import vme_pkg::*;

  logic       clock;
  logic       reset;
  logic       request_vme;
  logic       cpu_as;
  logic [3:0] vme_bg_in;
  logic       vme_bclr;
  logic       bus_acquired;
  logic       timeout_err;
  logic [3:0] vme_br;
  logic [3:0] vme_bg_out;
  logic       vme_bbsy_out;

  int n_vec;
  int n_err;

  vme_bus_requester #(
    .BUS_LEVEL (3),
    .BBSY_MIN  (3),
    .TIMEOUT   (8)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .request_vme  (request_vme),
    .cpu_as       (cpu_as),
    .vme_bg_in    (vme_bg_in),
    .vme_bclr     (vme_bclr),
    .bus_acquired (bus_acquired),
    .timeout_err  (timeout_err),
    .vme_br       (vme_br),
    .vme_bg_out   (vme_bg_out),
    .vme_bbsy_out (vme_bbsy_out)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic idle_inputs();
    request_vme = 1'b1;
    cpu_as      = 1'b1;
    vme_bg_in   = 4'b1111;
    vme_bclr    = 1'b1;
  endtask

  // Request, grant on level 3, then withdraw the grant; ends in OWNER
  task automatic go_owner();
    request_vme = 1'b0;
    step();
    vme_bg_in = 4'b0111;
    step(3);
    vme_bg_in = 4'b1111;
    step();
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    step(2);
    n_vec++;
    if ({bus_acquired, timeout_err, vme_br, vme_bg_out, vme_bbsy_out} !== 11'h7FF) begin
      $display("FAIL reset_outputs: got %b required %b",
               {bus_acquired, timeout_err, vme_br, vme_bg_out, vme_bbsy_out}, 11'h7FF);
      n_err++;
    end
    n_vec++;
    if (dut.r_state !== ST_IDLE) begin
      $display("FAIL reset_state: got %0d required %0d", dut.r_state, ST_IDLE);
      n_err++;
    end
    reset = 1'b0;
    step();
  endtask

  task automatic test_other_levels();
    vme_bg_in = 4'b1010;
    step(2);
    n_vec++;
    if (vme_bg_out !== 4'b1111) begin
      $display("FAIL passthru_latency: got %b required %b", vme_bg_out, 4'b1111);
      n_err++;
    end
    step();
    n_vec++;
    if (vme_bg_out !== 4'b1010) begin
      $display("FAIL passthru_levels: got %b required %b", vme_bg_out, 4'b1010);
      n_err++;
    end
    vme_bg_in = 4'b1111;
    step(3);
    n_vec++;
    if (vme_bg_out !== 4'b1111) begin
      $display("FAIL passthru_clear: got %b required %b", vme_bg_out, 4'b1111);
      n_err++;
    end
  endtask

  task automatic test_grant();
    request_vme = 1'b0;
    step();
    n_vec++;
    if (vme_br !== 4'b0111) begin
      $display("FAIL grant_br_asserted: got %b required %b", vme_br, 4'b0111);
      n_err++;
    end
    step(3);
    vme_bg_in = 4'b0111;
    step(2);
    n_vec++;
    if ({vme_br, vme_bbsy_out} !== 5'b01111) begin
      $display("FAIL grant_still_requesting: got %b required %b", {vme_br, vme_bbsy_out}, 5'b01111);
      n_err++;
    end
    step();
    n_vec++;
    if ({vme_br, vme_bbsy_out, bus_acquired, vme_bg_out[3]} !== 7'b1111011) begin
      $display("FAIL granted_cycle: got %b required %b",
               {vme_br, vme_bbsy_out, bus_acquired, vme_bg_out[3]}, 7'b1111011);
      n_err++;
    end
    step();
    n_vec++;
    if ({bus_acquired, vme_bbsy_out, vme_bg_out[3]} !== 3'b001) begin
      $display("FAIL owner_3_after_grant: got %b required %b",
               {bus_acquired, vme_bbsy_out, vme_bg_out[3]}, 3'b001);
      n_err++;
    end
    vme_bg_in   = 4'b1111;
    request_vme = 1'b1;
    step(3);
    n_vec++;
    if (bus_acquired !== 1'b0) begin
      $display("FAIL bbsy_min_hold: got %b required %b", bus_acquired, 1'b0);
      n_err++;
    end
    step();
    n_vec++;
    if ({bus_acquired, vme_bbsy_out} !== 2'b10) begin
      $display("FAIL release_cycle: got %b required %b", {bus_acquired, vme_bbsy_out}, 2'b10);
      n_err++;
    end
    step();
    n_vec++;
    if ({bus_acquired, vme_bbsy_out} !== 2'b11) begin
      $display("FAIL after_release: got %b required %b", {bus_acquired, vme_bbsy_out}, 2'b11);
      n_err++;
    end
    step(2);
  endtask

  task automatic test_pass();
    vme_bg_in = 4'b0111;
    step(2);
    n_vec++;
    if (vme_bg_out !== 4'b1111) begin
      $display("FAIL pass_latency: got %b required %b", vme_bg_out, 4'b1111);
      n_err++;
    end
    step();
    n_vec++;
    if (vme_bg_out !== 4'b0111) begin
      $display("FAIL pass_bg_out: got %b required %b", vme_bg_out, 4'b0111);
      n_err++;
    end
    request_vme = 1'b0;
    step(3);
    n_vec++;
    if ({vme_br, vme_bg_out} !== 8'b1111_0111) begin
      $display("FAIL pass_ignores_request: got %b required %b", {vme_br, vme_bg_out}, 8'b1111_0111);
      n_err++;
    end
    vme_bg_in = 4'b1111;
    step(2);
    n_vec++;
    if (vme_bg_out !== 4'b0111) begin
      $display("FAIL pass_held_sync: got %b required %b", vme_bg_out, 4'b0111);
      n_err++;
    end
    step();
    n_vec++;
    if ({vme_br, vme_bg_out} !== 8'b1111_1111) begin
      $display("FAIL pass_exit: got %b required %b", {vme_br, vme_bg_out}, 8'b1111_1111);
      n_err++;
    end
    step();
    n_vec++;
    if (vme_br !== 4'b0111) begin
      $display("FAIL request_after_pass: got %b required %b", vme_br, 4'b0111);
      n_err++;
    end
    request_vme = 1'b1;
    step();
    n_vec++;
    if ({vme_br, timeout_err} !== 5'b11111) begin
      $display("FAIL withdraw_no_pulse: got %b required %b", {vme_br, timeout_err}, 5'b11111);
      n_err++;
    end
    step(2);
  endtask

  task automatic test_timeout();
    request_vme = 1'b0;
    step(8);
    n_vec++;
    if ({vme_br, timeout_err} !== 5'b01111) begin
      $display("FAIL timeout_early: got %b required %b", {vme_br, timeout_err}, 5'b01111);
      n_err++;
    end
    step();
    n_vec++;
    if ({vme_br, timeout_err} !== 5'b11110) begin
      $display("FAIL timeout_pulse: got %b required %b", {vme_br, timeout_err}, 5'b11110);
      n_err++;
    end
    n_vec++;
    if (dut.r_state !== ST_IDLE) begin
      $display("FAIL timeout_state: got %0d required %0d", dut.r_state, ST_IDLE);
      n_err++;
    end
    request_vme = 1'b1;
    step();
    n_vec++;
    if ({vme_br, timeout_err} !== 5'b11111) begin
      $display("FAIL timeout_one_cycle: got %b required %b", {vme_br, timeout_err}, 5'b11111);
      n_err++;
    end
    step();
  endtask

  task automatic test_grant_timeout_tie();
    request_vme = 1'b0;
    step(6);
    vme_bg_in = 4'b0111;
    step(3);
    n_vec++;
    if ({vme_bbsy_out, timeout_err} !== 2'b01) begin
      $display("FAIL tie_grant_wins: got %b required %b", {vme_bbsy_out, timeout_err}, 2'b01);
      n_err++;
    end
    n_vec++;
    if (dut.r_state !== ST_GRANTED) begin
      $display("FAIL tie_state: got %0d required %0d", dut.r_state, ST_GRANTED);
      n_err++;
    end
    vme_bg_in   = 4'b1111;
    request_vme = 1'b1;
    step(7);
    n_vec++;
    if ({bus_acquired, vme_bbsy_out, vme_br} !== 6'b111111) begin
      $display("FAIL tie_released: got %b required %b", {bus_acquired, vme_bbsy_out, vme_br}, 6'b111111);
      n_err++;
    end
  endtask

  task automatic test_cpu_hold();
    go_owner();
    cpu_as = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (i == 2) request_vme = 1'b1;
      step();
      n_vec++;
      if (bus_acquired !== 1'b0) begin
        $display("FAIL cpu_hold_cycle%0d: got %b required %b", i, bus_acquired, 1'b0);
        n_err++;
      end
    end
    cpu_as = 1'b1;
    step();
    n_vec++;
    if ({bus_acquired, vme_bbsy_out} !== 2'b10) begin
      $display("FAIL cpu_release: got %b required %b", {bus_acquired, vme_bbsy_out}, 2'b10);
      n_err++;
    end
    step();
    n_vec++;
    if ({bus_acquired, vme_bbsy_out} !== 2'b11) begin
      $display("FAIL cpu_bbsy_off: got %b required %b", {bus_acquired, vme_bbsy_out}, 2'b11);
      n_err++;
    end
    step(2);
  endtask

  task automatic test_bclr();
    go_owner();
    cpu_as   = 1'b0;
    vme_bclr = 1'b0;
    step(6);
    n_vec++;
    if (bus_acquired !== 1'b0) begin
      $display("FAIL bclr_waits_cpu: got %b required %b", bus_acquired, 1'b0);
      n_err++;
    end
    cpu_as = 1'b1;
    step();
    n_vec++;
    if ({bus_acquired, vme_bbsy_out} !== 2'b10) begin
      $display("FAIL bclr_release: got %b required %b", {bus_acquired, vme_bbsy_out}, 2'b10);
      n_err++;
    end
    step();
    n_vec++;
    if ({vme_bbsy_out, vme_br} !== 5'b11111) begin
      $display("FAIL idle_gap: got %b required %b", {vme_bbsy_out, vme_br}, 5'b11111);
      n_err++;
    end
    step();
    n_vec++;
    if (vme_br !== 4'b0111) begin
      $display("FAIL rerequest: got %b required %b", vme_br, 4'b0111);
      n_err++;
    end
    vme_bclr    = 1'b1;
    request_vme = 1'b1;
    step(3);
  endtask

  task automatic test_reset_mid();
    go_owner();
    cpu_as = 1'b0;
    step();
    n_vec++;
    if (bus_acquired !== 1'b0) begin
      $display("FAIL mid_owner_setup: got %b required %b", bus_acquired, 1'b0);
      n_err++;
    end
    reset = 1'b1;
    step();
    n_vec++;
    if ({bus_acquired, timeout_err, vme_br, vme_bg_out, vme_bbsy_out} !== 11'h7FF) begin
      $display("FAIL reset_mid_owner: got %b required %b",
               {bus_acquired, timeout_err, vme_br, vme_bg_out, vme_bbsy_out}, 11'h7FF);
      n_err++;
    end
    n_vec++;
    if (dut.r_state !== ST_IDLE) begin
      $display("FAIL reset_mid_owner_state: got %0d required %0d", dut.r_state, ST_IDLE);
      n_err++;
    end
    idle_inputs();
    step();
    reset = 1'b0;
    vme_bg_in = 4'b0111;
    step(3);
    n_vec++;
    if (vme_bg_out !== 4'b0111) begin
      $display("FAIL mid_pass_setup: got %b required %b", vme_bg_out, 4'b0111);
      n_err++;
    end
    reset = 1'b1;
    step();
    n_vec++;
    if (vme_bg_out !== 4'b1111) begin
      $display("FAIL reset_mid_pass: got %b required %b", vme_bg_out, 4'b1111);
      n_err++;
    end
    vme_bg_in = 4'b1111;
    step(2);
    reset = 1'b0;
    step();
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    reset = 1'b1;
    idle_inputs();
    test_reset();
    test_other_levels();
    test_grant();
    test_pass();
    test_timeout();
    test_grant_timeout_tie();
    test_cpu_hold();
    test_bclr();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
